// File: rtl/cnt1_seq_ctrl.sv
// cnt1_seq_ctrl: sequencer in front of the cnt1 popcount pre-stage.
// Accepts a fingerprint beat stream, forwards aligned beats to cnt1 and tags
// each cnt1 result with its vector id and set (reference/query).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_Start; counts latched on start
// REF    | accepting reference vectors
// QRY    | accepting query vectors
// FLUSH  | intake closed, draining the tag pipe
// DONE   | one-cycle o_Done pulse, then back to IDLE
module cnt1_seq_ctrl #(
  parameter int BUS_WIDTH     = 128,
  parameter int SUB_VECTOR_NO = 2,
  parameter int CNT1_LATENCY  = 4,
  parameter int VEC_ID_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_Start,
  input  logic [VEC_ID_WIDTH-1:0] i_RefNo,
  input  logic [VEC_ID_WIDTH-1:0] i_QueryNo,
  input  logic                    i_Hold,
  input  logic [BUS_WIDTH-1:0]    s_Vector,
  input  logic                    s_Valid,
  input  logic                    s_Last,
  output logic                    s_Ready,
  output logic [BUS_WIDTH-1:0]    o_Cnt1Vector,
  output logic                    o_Cnt1Valid,
  output logic                    o_TagValid,
  output logic                    o_TagIsRef,
  output logic [VEC_ID_WIDTH-1:0] o_TagId,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic                    o_FrameErr
);

  localparam int PH_W      = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int FL_W      = (CNT1_LATENCY > 0) ? $clog2(CNT1_LATENCY + 1) : 1;
  localparam int TAG_DEPTH = 1 + CNT1_LATENCY;

  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(SUB_VECTOR_NO - 1);
  localparam logic [FL_W-1:0]         FL_LOAD = FL_W'(CNT1_LATENCY);
  localparam logic [VEC_ID_WIDTH-1:0] ID_ONE  = VEC_ID_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REF   = 3'd1,
    S_QRY   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic                    is_ref;
    logic [VEC_ID_WIDTH-1:0] id;
  } tag_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [VEC_ID_WIDTH-1:0] vec_id_q, vec_id_d;
  logic [VEC_ID_WIDTH-1:0] ref_no_q, ref_no_d;
  logic [VEC_ID_WIDTH-1:0] qry_no_q, qry_no_d;
  logic [FL_W-1:0]         flush_q, flush_d;
  logic                    frame_err_q, frame_err_d;
  logic [BUS_WIDTH-1:0]    cnt1_vec_q;
  logic                    cnt1_valid_q;
  tag_t                    tag_q [TAG_DEPTH];
  tag_t                    tag_in;

  logic intake, accept, beat_last, vec_done;
  logic vec_last_ref, vec_last_qry, final_beat;

  // Intake handshake and vector-boundary decode
  always_comb begin
    intake       = (state_q == S_REF) || (state_q == S_QRY);
    s_Ready      = intake && ((phase_q != '0) || !i_Hold);
    accept       = s_Valid && s_Ready;
    beat_last    = (phase_q == PH_LAST);
    vec_done     = accept && beat_last;
    vec_last_ref = (vec_id_q == ref_no_q - ID_ONE);
    vec_last_qry = (vec_id_q == qry_no_q - ID_ONE);
    final_beat   = beat_last &&
                   (((state_q == S_REF) && vec_last_ref && (qry_no_q == '0)) ||
                    ((state_q == S_QRY) && vec_last_qry));
  end

  // Next-state, counters and framing-error logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    vec_id_d    = vec_id_q;
    ref_no_d    = ref_no_q;
    qry_no_d    = qry_no_q;
    flush_d     = flush_q;
    frame_err_d = frame_err_q;

    if (accept) begin
      phase_d = beat_last ? '0 : phase_q + PH_W'(1);
      if (s_Last != final_beat) frame_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          ref_no_d    = i_RefNo;
          qry_no_d    = i_QueryNo;
          frame_err_d = 1'b0;
          vec_id_d    = '0;
          phase_d     = '0;
          flush_d     = FL_LOAD;
          if (i_RefNo != '0)        state_d = S_REF;
          else if (i_QueryNo != '0) state_d = S_QRY;
          else                      state_d = S_FLUSH;
        end
      end
      S_REF: begin
        if (vec_done) begin
          if (vec_last_ref) begin
            vec_id_d = '0;
            flush_d  = FL_LOAD;
            state_d  = (qry_no_q != '0) ? S_QRY : S_FLUSH;
          end else begin
            vec_id_d = vec_id_q + ID_ONE;
          end
        end
      end
      S_QRY: begin
        if (vec_done) begin
          if (vec_last_qry) begin
            flush_d = FL_LOAD;
            state_d = S_FLUSH;
          end else begin
            vec_id_d = vec_id_q + ID_ONE;
          end
        end
      end
      // Counts CNT1_LATENCY down to 0 inclusive so the whole tag pipe drains
      S_FLUSH: begin
        if (flush_q == '0) state_d = S_DONE;
        else               flush_d = flush_q - FL_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      vec_id_q    <= '0;
      ref_no_q    <= '0;
      qry_no_q    <= '0;
      flush_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      vec_id_q    <= vec_id_d;
      ref_no_q    <= ref_no_d;
      qry_no_q    <= qry_no_d;
      flush_q     <= flush_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Registered beat forwarding to cnt1; the vector holds when nothing is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt1_vec_q   <= '0;
      cnt1_valid_q <= 1'b0;
    end else begin
      cnt1_valid_q <= accept;
      if (accept) cnt1_vec_q <= s_Vector;
    end
  end

  // Tag entry; id/set are zeroed on empty slots so the outputs read 0
  always_comb begin
    tag_in = '0;
    if (vec_done) begin
      tag_in.valid  = 1'b1;
      tag_in.is_ref = (state_q == S_REF);
      tag_in.id     = vec_id_q;
    end
  end

  // Tag shift register aligned with cnt1 result latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign o_Cnt1Vector = cnt1_vec_q;
  assign o_Cnt1Valid  = cnt1_valid_q;
  assign o_TagValid   = tag_q[TAG_DEPTH-1].valid;
  assign o_TagIsRef   = tag_q[TAG_DEPTH-1].is_ref;
  assign o_TagId      = tag_q[TAG_DEPTH-1].id;
  assign o_Busy       = (state_q != S_IDLE);
  assign o_Done       = (state_q == S_DONE);
  assign o_FrameErr   = frame_err_q;

endmodule

// File: tb/tb_cnt1_seq_ctrl.sv
// Bench for cnt1_seq_ctrl: job table, hand-written corner sequences and
// randomized jobs, all checked every cycle against a beat-count reference model.
module tb_cnt1_seq_ctrl;
  localparam int BW  = 128;
  localparam int SVN = 2;
  localparam int LAT = 4;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           i_Start = 1'b0;
  logic [W-1:0]   i_RefNo = '0;
  logic [W-1:0]   i_QueryNo = '0;
  logic           i_Hold = 1'b0;
  logic [BW-1:0]  s_Vector = '0;
  logic           s_Valid = 1'b0;
  logic           s_Last = 1'b0;
  logic           s_Ready;
  logic [BW-1:0]  o_Cnt1Vector;
  logic           o_Cnt1Valid;
  logic           o_TagValid;
  logic           o_TagIsRef;
  logic [W-1:0]   o_TagId;
  logic           o_Busy;
  logic           o_Done;
  logic           o_FrameErr;

  cnt1_seq_ctrl #(.BUS_WIDTH(BW), .SUB_VECTOR_NO(SVN), .CNT1_LATENCY(LAT), .VEC_ID_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .i_Start(i_Start), .i_RefNo(i_RefNo), .i_QueryNo(i_QueryNo),
    .i_Hold(i_Hold), .s_Vector(s_Vector), .s_Valid(s_Valid), .s_Last(s_Last), .s_Ready(s_Ready),
    .o_Cnt1Vector(o_Cnt1Vector), .o_Cnt1Valid(o_Cnt1Valid), .o_TagValid(o_TagValid),
    .o_TagIsRef(o_TagIsRef), .o_TagId(o_TagId), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_FrameErr(o_FrameErr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int tag_seen = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; bit isref; int id; } tag_e_t;
  tag_e_t        tq[$];
  bit            m_busy = 0;
  int            m_beats = 0, m_total = 0, m_ref = 0, m_qry = 0, m_done = -1;
  bit            m_cv = 0, m_err = 0;
  logic [BW-1:0] m_vec = '0;

  always @(negedge clk) begin
    bit     er, acc, fin;
    int     vec;
    tag_e_t e;
    if (!rstn) begin
      m_busy = 0; m_beats = 0; m_total = 0; m_done = -1; m_cv = 0; m_err = 0; m_vec = '0;
      tq.delete();
      chk("rst_busy", o_Busy, 0);
      chk("rst_tag", o_TagValid, 0);
      chk("rst_cv", o_Cnt1Valid, 0);
    end else begin
      er = m_busy && (m_beats < m_total) && (((m_beats % SVN) != 0) || !i_Hold);
      chk("s_Ready", s_Ready, er);
      chk("o_Busy", o_Busy, m_busy);
      chk("o_Done", o_Done, (cyc == m_done));
      chk("o_FrameErr", o_FrameErr, m_err);
      chk("o_Cnt1Valid", o_Cnt1Valid, m_cv);
      chk("o_Cnt1Vector", o_Cnt1Vector, m_vec);
      if (tq.size() > 0 && tq[0].due == cyc) begin
        e = tq.pop_front();
        chk("tag_valid", o_TagValid, 1);
        chk("tag_isref", o_TagIsRef, e.isref);
        chk("tag_id", o_TagId, e.id);
      end else begin
        chk("tag_valid", o_TagValid, 0);
        chk("tag_isref", o_TagIsRef, 0);
        chk("tag_id", o_TagId, 0);
      end
      if (o_TagValid) tag_seen++;

      acc = er && s_Valid;
      m_cv = acc;
      if (acc) begin
        m_vec = s_Vector;
        fin = (m_beats == m_total - 1);
        if (s_Last !== fin) m_err = 1;
        if ((m_beats % SVN) == SVN - 1) begin
          vec = m_beats / SVN;
          e.due = cyc + 1 + LAT;
          e.isref = (vec < m_ref);
          e.id = e.isref ? vec : vec - m_ref;
          tq.push_back(e);
        end
        m_beats++;
        if (m_beats == m_total) m_done = cyc + LAT + 2;
      end
      if (!m_busy && i_Start) begin
        m_ref = int'(i_RefNo); m_qry = int'(i_QueryNo);
        m_total = (m_ref + m_qry) * SVN;
        m_beats = 0; m_busy = 1; m_err = 0;
        if (m_total == 0) m_done = cyc + LAT + 2;
      end else if (m_busy && cyc == m_done) begin
        m_busy = 0; m_done = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input int rn, input int qn, output int s);
    i_Start = 1; i_RefNo = W'(rn); i_QueryNo = W'(qn);
    @(negedge clk); s = cyc;
    @(posedge clk); #1;
    i_Start = 0; i_RefNo = W'($urandom); i_QueryNo = W'($urandom);
  endtask

  task automatic feed(input int total, input int last_pos, input int vprob, input int hprob, input bit rstart);
    int k = 0, guard = 0;
    while (k < total && guard < 2000) begin
      s_Valid  = ($urandom_range(99) < vprob);
      s_Vector = {$urandom, $urandom, $urandom, $urandom};
      s_Last   = s_Valid && (k + 1 == last_pos);
      i_Hold   = ($urandom_range(99) < hprob);
      i_Start  = rstart && ($urandom_range(9) == 0);
      if (i_Start) begin i_RefNo = W'($urandom_range(3)); i_QueryNo = W'($urandom_range(3)); end
      @(negedge clk);
      if (s_Valid && s_Ready) k++;
      @(posedge clk); #1;
      guard++;
    end
    s_Valid = 0; s_Last = 0; i_Hold = 0; i_Start = 0;
    if (guard >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL feed_timeout got=%0d beats exp=%0d", k, total);
    end
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_Done) begin d = cyc; break; end
    end
    @(posedge clk); #1;
    if (d < 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout got=none exp=o_Done within 40 cycles");
    end
  endtask

  task automatic step(input bit v, input bit h, input bit l, output bit rdy, output bit cv);
    s_Valid = v; i_Hold = h; s_Last = l;
    s_Vector = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    rdy = s_Ready; cv = o_Cnt1Valid;
    @(posedge clk); #1;
  endtask

  typedef struct { int refn; int qryn; int last_pos; bit exp_err; int exp_tags; } job_t;

  initial begin
    job_t jobs[7];
    int s, d, t0, zeros;
    bit r, cv;

    jobs[0] = '{2, 2, 8, 0, 4};
    jobs[1] = '{0, 1, 2, 0, 1};
    jobs[2] = '{0, 0, 0, 0, 0};
    jobs[3] = '{2, 0, 3, 1, 2};
    jobs[4] = '{1, 1, 0, 1, 2};
    jobs[5] = '{3, 1, 8, 0, 4};
    jobs[6] = '{1, 0, 2, 0, 1};

    #2 rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_Busy, 0);
    chk("reset_done", o_Done, 0);
    chk("reset_err", o_FrameErr, 0);
    chk("reset_ready", s_Ready, 0);
    chk("reset_vec", o_Cnt1Vector, 0);
    rstn = 1;
    @(posedge clk); #1;

    // table of back-to-back jobs
    for (int j = 0; j < 7; j++) begin
      t0 = tag_seen;
      start_job(jobs[j].refn, jobs[j].qryn, s);
      chk("err_cleared", o_FrameErr, 0);
      feed((jobs[j].refn + jobs[j].qryn) * SVN, jobs[j].last_pos, 100, 0, 0);
      wait_done(d);
      chk("done_lat", d - s, (jobs[j].refn + jobs[j].qryn) * SVN + LAT + 2);
      chk("job_err", o_FrameErr, jobs[j].exp_err);
      chk("job_tags", tag_seen - t0, jobs[j].exp_tags);
    end

    // i_Hold only honoured at vector boundaries
    start_job(1, 1, s);
    step(1, 0, 0, r, cv); chk("hold_b0", r, 1);
    step(1, 1, 0, r, cv); chk("hold_b1", r, 1);
    step(1, 1, 0, r, cv); chk("hold_stall0", r, 0);
    step(1, 1, 0, r, cv); chk("hold_stall1", r, 0);
    step(1, 0, 0, r, cv); chk("hold_b2", r, 1);
    step(1, 1, 1, r, cv); chk("hold_b3", r, 1);
    s_Valid = 0; s_Last = 0; i_Hold = 0;
    wait_done(d);
    chk("hold_err", o_FrameErr, 0);

    // s_Valid gap in the middle of a vector
    t0 = tag_seen;
    zeros = 0;
    start_job(1, 0, s);
    step(1, 0, 0, r, cv); chk("gap_b0", r, 1);
    step(0, 0, 0, r, cv); chk("gap_cv_b0", cv, 1);
    for (int i = 0; i < 3; i++) begin
      step((i == 2), 0, (i == 2), r, cv);
      if (!cv) zeros++;
    end
    chk("gap_b1_ready", r, 1);
    step(0, 0, 0, r, cv); chk("gap_cv_b1", cv, 1);
    chk("gap_low_cycles", zeros, 3);
    wait_done(d);
    chk("gap_tags", tag_seen - t0, 1);
    chk("gap_err", o_FrameErr, 0);

    // reset in the middle of the query set drops in-flight tags
    start_job(1, 2, s);
    feed(3, 0, 100, 0, 0);
    rstn = 0;
    #1;
    chk("midrst_busy", o_Busy, 0);
    chk("midrst_cv", o_Cnt1Valid, 0);
    chk("midrst_ready", s_Ready, 0);
    chk("midrst_tag", o_TagValid, 0);
    chk("midrst_vec", o_Cnt1Vector, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1;
    t0 = tag_seen;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_tags", tag_seen - t0, 0);
    t0 = tag_seen;
    start_job(2, 2, s);
    feed(8, 8, 100, 0, 0);
    wait_done(d);
    chk("postrst_tags", tag_seen - t0, 4);
    chk("postrst_err", o_FrameErr, 0);

    // randomized jobs, with stray i_Start pulses and count changes mid-job
    for (int j = 0; j < 30; j++) begin
      int rn, qn, tot, lp;
      rn = $urandom_range(3);
      qn = $urandom_range(3);
      tot = (rn + qn) * SVN;
      lp = ($urandom_range(3) == 0) ? $urandom_range(tot) : tot;
      start_job(rn, qn, s);
      feed(tot, lp, 70, 30, 1);
      wait_done(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
